// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - one requester's view of the shared RAM data port
interface ram_port_arbiter_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  req;
   logic [3:0]            we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           din;
   logic                  lock;
   logic                  gnt;
   logic                  rvalid;
   logic [31:0]           rdata;

   modport master (
      output req, we, addr, din, lock,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, din, lock,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin, burst-lockable arbiter for RAM data port A
module ram_port_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int MAX_BURST  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ram_port_arbiter_if.slave     m0,
   ram_port_arbiter_if.slave     m1,
   output logic [3:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_din,
   input  logic [31:0]           ram_dout
);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_BURST);

   typedef enum logic [1:0] {ARB, HOLD0, HOLD1} state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_valid_q, pend_valid_d;
   logic             pend_id_q, pend_id_d;

   logic             arb_open;
   logic             gnt0, gnt1;
   logic             granted, sel;
   logic [3:0]       sel_we;
   logic             sel_lock, other_req;
   logic [CNT_W:0]   next_cnt;

   always_comb begin
      state_d      = state_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      pend_valid_d = 1'b0;
      pend_id_d    = pend_id_q;
      gnt0         = 1'b0;
      gnt1         = 1'b0;
      ram_we       = '0;
      ram_addr     = '0;
      ram_din      = '0;

      // A holder that drops req gives the port back within the same cycle.
      arb_open = (state_q == ARB) ||
                 (state_q == HOLD0 && !m0.req) ||
                 (state_q == HOLD1 && !m1.req);

      if (rst_n) begin
         if (arb_open) begin
            if (m0.req && (!m1.req || last_q))
               gnt0 = 1'b1;
            else if (m1.req)
               gnt1 = 1'b1;
         end else if (state_q == HOLD0) begin
            gnt0 = 1'b1;
         end else begin
            gnt1 = 1'b1;
         end
      end

      granted   = gnt0 | gnt1;
      sel       = gnt1;
      sel_we    = sel ? m1.we   : m0.we;
      sel_lock  = sel ? m1.lock : m0.lock;
      other_req = sel ? m0.req  : m1.req;
      next_cnt  = (arb_open ? '0 : {1'b0, cnt_q}) + 1'b1;

      if (granted) begin
         ram_we       = sel_we;
         ram_addr     = sel ? m1.addr : m0.addr;
         ram_din      = sel ? m1.din  : m0.din;
         last_d       = sel;
         pend_valid_d = (sel_we == 4'b0000);
         if (sel_we == 4'b0000)
            pend_id_d = sel;
         // Burst length only matters when the other side is waiting; saturate otherwise.
         if (sel_lock && !(other_req && next_cnt >= MAX_CNT)) begin
            state_d = sel ? HOLD1 : HOLD0;
            cnt_d   = (next_cnt >= MAX_CNT) ? MAX_CNT[CNT_W-1:0] : next_cnt[CNT_W-1:0];
         end else begin
            state_d = ARB;
            cnt_d   = '0;
         end
      end else if (arb_open) begin
         state_d = ARB;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ARB;
         last_q       <= 1'b1;
         cnt_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_id_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         pend_valid_q <= pend_valid_d;
         pend_id_q    <= pend_id_d;
      end
   end

   assign m0.gnt    = gnt0;
   assign m1.gnt    = gnt1;
   // Masking with rst_n kills the response of a read granted just before reset.
   assign m0.rvalid = rst_n & pend_valid_q & ~pend_id_q;
   assign m1.rvalid = rst_n & pend_valid_q &  pend_id_q;
   assign m0.rdata  = ram_dout;
   assign m1.rdata  = ram_dout;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;
   localparam int AW = 12;
   localparam int MB = 4;

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } sb_t;

   logic          clk;
   logic          rst_n;
   logic [3:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic [31:0]   shadow [int];
   sb_t           sb[$];
   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;

   ram_port_arbiter_if #(.ADDR_WIDTH(AW)) m0_if ();
   ram_port_arbiter_if #(.ADDR_WIDTH(AW)) m1_if ();

   ram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m0       (m0_if),
      .m1       (m1_if),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      logic [31:0] w;
      w = mem[ram_addr];
      for (int i = 0; i < 4; i++)
         if (ram_we[i]) w[8*i +: 8] = ram_din[8*i +: 8];
      mem[ram_addr] <= w;
      ram_dout      <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] shadow_rd(input int a);
      return shadow.exists(a) ? shadow[a] : 32'h0;
   endfunction

   task automatic drive(input int n, input logic req, input logic [3:0] we,
                        input logic [AW-1:0] addr, input logic [31:0] din, input logic lock);
      if (n == 0) begin
         m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.din = din; m0_if.lock = lock;
      end else begin
         m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.din = din; m1_if.lock = lock;
      end
   endtask

   task automatic idle(input int n);
      drive(n, 1'b0, 4'h0, '0, 32'h0, 1'b0);
   endtask

   task automatic tick(output logic g0, output logic g1);
      sb_t           e;
      int            n;
      logic [3:0]    we;
      logic [AW-1:0] addr;
      logic [31:0]   din;
      logic [31:0]   v;
      #1;
      if (!rst_n) begin
         sb.delete();
         chk("rst_gnt0", m0_if.gnt, 0);
         chk("rst_gnt1", m1_if.gnt, 0);
         chk("rst_ram_we", ram_we, 0);
         chk("rst_ram_addr", ram_addr, 0);
         chk("rst_ram_din", ram_din, 0);
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         if (e.id == 0) begin
            chk("rvalid0", m0_if.rvalid, 1);
            chk("rvalid1_quiet", m1_if.rvalid, 0);
            chk("rdata0", m0_if.rdata, e.data);
         end else begin
            chk("rvalid1", m1_if.rvalid, 1);
            chk("rvalid0_quiet", m0_if.rvalid, 0);
            chk("rdata1", m1_if.rdata, e.data);
         end
      end else begin
         chk("no_rvalid0", m0_if.rvalid, 0);
         chk("no_rvalid1", m1_if.rvalid, 0);
      end
      g0 = m0_if.gnt;
      g1 = m1_if.gnt;
      chk("gnt_onehot", g0 & g1, 0);
      if (g0 ^ g1) begin
         n    = g1 ? 1 : 0;
         we   = g1 ? m1_if.we   : m0_if.we;
         addr = g1 ? m1_if.addr : m0_if.addr;
         din  = g1 ? m1_if.din  : m0_if.din;
         chk("ram_addr", ram_addr, addr);
         chk("ram_we", ram_we, we);
         if (we == 4'h0) begin
            sb.push_back('{id: n, data: shadow_rd(int'(addr)), due: cyc + 1});
         end else begin
            chk("ram_din", ram_din, din);
            v = shadow_rd(int'(addr));
            for (int i = 0; i < 4; i++)
               if (we[i]) v[8*i +: 8] = din[8*i +: 8];
            shadow[int'(addr)] = v;
         end
      end else begin
         chk("idle_ram_we", ram_we, 0);
      end
      @(negedge clk);
      cyc++;
   endtask

   initial begin
      logic g0, g1;
      int   done0, done1, rem0, rem1;
      int   exp4 [12];
      exp4 = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
      for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
      ram_dout = 32'h0;

      rst_n = 1'b0;
      drive(0, 1'b1, 4'h0, 12'd3, 32'h0, 1'b0);
      drive(1, 1'b1, 4'hF, 12'd4, 32'hDEADBEEF, 1'b0);
      tick(g0, g1);
      tick(g0, g1);
      rst_n = 1'b1;
      idle(0); idle(1);
      tick(g0, g1);

      drive(0, 1'b1, 4'hF, 12'd5, 32'h11223344, 1'b0);
      tick(g0, g1);
      chk("t1_wr_g0", g0, 1);
      chk("t1_wr_g1", g1, 0);
      drive(0, 1'b1, 4'h0, 12'd5, 32'h0, 1'b0);
      tick(g0, g1);
      chk("t1_rd_g0", g0, 1);
      idle(0);
      tick(g0, g1);

      rst_n = 1'b0;
      tick(g0, g1);
      rst_n = 1'b1;
      done0 = 0; done1 = 0;
      for (int k = 0; k < 6; k++) begin
         drive(0, done0 < 3, 4'h0, AW'(5 + 2 * (done0 % 2)), 32'h0, 1'b0);
         drive(1, done1 < 3, 4'h0, AW'(32 + done1), 32'h0, 1'b0);
         tick(g0, g1);
         chk("t2_order_g0", g0, (k % 2) == 0);
         chk("t2_order_g1", g1, (k % 2) == 1);
         if (g0) done0++;
         if (g1) done1++;
      end
      idle(0); idle(1);
      tick(g0, g1);

      drive(0, 1'b1, 4'hF, 12'd7, 32'hAABBCCDD, 1'b0);
      tick(g0, g1);
      chk("t3_wr0_g0", g0, 1);
      idle(0);
      drive(1, 1'b1, 4'h1, 12'd7, 32'h00000099, 1'b0);
      tick(g0, g1);
      chk("t3_wr1_g1", g1, 1);
      drive(1, 1'b1, 4'h0, 12'd7, 32'h0, 1'b0);
      tick(g0, g1);
      chk("t3_rd1_g1", g1, 1);
      idle(1);
      tick(g0, g1);

      rem0 = 2; rem1 = 10;
      for (int k = 0; k < 12; k++) begin
         drive(1, rem1 > 0, 4'h0, (rem1 % 2) ? 12'd5 : 12'd7, 32'h0, 1'b1);
         drive(0, (k >= 1) && (rem0 > 0), 4'h0, 12'd7, 32'h0, 1'b0);
         tick(g0, g1);
         chk("t4_burst_g1", g1, exp4[k]);
         chk("t4_burst_g0", g0, exp4[k] == 0);
         if (g0) rem0--;
         if (g1) rem1--;
      end
      idle(0); idle(1);
      tick(g0, g1);

      drive(0, 1'b1, 4'h0, 12'd5, 32'h0, 1'b1);
      tick(g0, g1);
      chk("t5_lock_g0", g0, 1);
      drive(0, 1'b1, 4'h0, 12'd7, 32'h0, 1'b1);
      drive(1, 1'b1, 4'h0, 12'd5, 32'h0, 1'b0);
      tick(g0, g1);
      chk("t5_hold_g0", g0, 1);
      chk("t5_hold_g1", g1, 0);
      idle(0);
      tick(g0, g1);
      chk("t5_drop_g1", g1, 1);
      chk("t5_drop_g0", g0, 0);
      idle(1);
      tick(g0, g1);

      drive(0, 1'b1, 4'h0, 12'd5, 32'h0, 1'b0);
      tick(g0, g1);
      chk("t6_rd_g0", g0, 1);
      idle(0);
      rst_n = 1'b0;
      tick(g0, g1);
      tick(g0, g1);
      rst_n = 1'b1;
      drive(0, 1'b1, 4'h0, 12'd7, 32'h0, 1'b0);
      drive(1, 1'b1, 4'h0, 12'd5, 32'h0, 1'b0);
      tick(g0, g1);
      chk("t6_tie_g0", g0, 1);
      chk("t6_tie_g1", g1, 0);
      idle(0); idle(1);
      tick(g0, g1);
      tick(g0, g1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
